// File: rtl/comm_link_controller.sv
// Pong serial-link sequencer: presence probe with timeout/retry, arbitration of game
// sends and link-level replies onto one transmitter, and receiver acknowledge/forwarding.
module comm_link_controller #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned MAX_RETRIES    = 3,
  parameter int unsigned TO_W           = 20
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_ball,
  input  logic [8:0]  ball_y,
  input  logic [3:0]  vel_x,
  input  logic [3:0]  vel_y,
  input  logic        sign_y,
  input  logic        req_miss,
  input  logic        i_lost,
  input  logic        req_new_game,
  output logic [2:0]  grant,
  output logic        tx_start,
  output logic [23:0] tx_message,
  input  logic        tx_busy,
  input  logic        rx_new_message,
  input  logic        rx_are_you_there,
  input  logic        rx_I_am_here,
  output logic        rx_message_acked,
  output logic        rx_deliver,
  output logic        link_up,
  output logic        link_fail
);

  localparam logic [2:0] PROBE_SEND = 3'd0;
  localparam logic [2:0] PROBE_TX   = 3'd1;
  localparam logic [2:0] PROBE_WAIT = 3'd2;
  localparam logic [2:0] IDLE       = 3'd3;
  localparam logic [2:0] TX         = 3'd4;
  localparam logic [2:0] DEAD       = 3'd5;
  localparam logic [2:0] DEAD_TX    = 3'd6;

  localparam int unsigned RC_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [RC_W-1:0] MAX_RC  = RC_W'(MAX_RETRIES);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [23:0] MSG_ARE_YOU_THERE = 24'h000010;
  localparam logic [23:0] MSG_I_AM_HERE     = 24'h000008;
  localparam logic [23:0] MSG_NEW_GAME      = 24'h000001;

  logic [2:0]      state;
  logic [TO_W-1:0] to_cnt;
  logic [RC_W-1:0] retry_cnt;
  logic            pending_reply;
  logic            tx_busy_q;
  logic            rx_new_q;

  logic rx_event;
  logic rx_ayt_ev;
  logic rx_iah_ev;
  logic rx_game_ev;
  logic busy_fall;

  // A message is consumed once per assertion of rx_new_message, however long it is held.
  always_comb begin
    rx_event   = rx_new_message & ~rx_new_q;
    rx_ayt_ev  = rx_event & rx_are_you_there;
    rx_iah_ev  = rx_event & ~rx_are_you_there & rx_I_am_here;
    rx_game_ev = rx_event & ~rx_are_you_there & ~rx_I_am_here;
    busy_fall  = tx_busy_q & ~tx_busy;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= PROBE_SEND;
      to_cnt           <= '0;
      retry_cnt        <= '0;
      pending_reply    <= 1'b0;
      tx_busy_q        <= 1'b0;
      rx_new_q         <= 1'b0;
      grant            <= '0;
      tx_start         <= 1'b0;
      tx_message       <= '0;
      rx_message_acked <= 1'b0;
      rx_deliver       <= 1'b0;
      link_up          <= 1'b0;
      link_fail        <= 1'b0;
    end else begin
      tx_start         <= 1'b0;
      grant            <= '0;
      tx_busy_q        <= tx_busy;
      rx_new_q         <= rx_new_message;
      rx_message_acked <= rx_event;
      rx_deliver       <= rx_game_ev;

      if (rx_iah_ev && state == PROBE_WAIT) link_up <= 1'b1;

      case (state)
        PROBE_SEND: begin
          if (!tx_busy) begin
            tx_message <= MSG_ARE_YOU_THERE;
            tx_start   <= 1'b1;
            state      <= PROBE_TX;
          end
        end
        PROBE_TX: begin
          if (busy_fall) begin
            to_cnt <= '0;
            state  <= PROBE_WAIT;
          end
        end
        PROBE_WAIT: begin
          if (to_cnt != '1) to_cnt <= to_cnt + 1'b1;
          // A reply landing in the timeout cycle itself takes precedence over the retry.
          if (link_up || rx_iah_ev) begin
            state <= IDLE;
          end else if (to_cnt == TO_LAST) begin
            if (retry_cnt < MAX_RC) begin
              retry_cnt <= retry_cnt + 1'b1;
              state     <= PROBE_SEND;
            end else begin
              link_fail <= 1'b1;
              state     <= DEAD;
            end
          end
        end
        IDLE: begin
          if (!tx_busy) begin
            if (pending_reply) begin
              tx_message    <= MSG_I_AM_HERE;
              tx_start      <= 1'b1;
              pending_reply <= 1'b0;
              state         <= TX;
            end else if (link_up && req_new_game) begin
              tx_message <= MSG_NEW_GAME;
              tx_start   <= 1'b1;
              grant      <= 3'b100;
              state      <= TX;
            end else if (link_up && req_miss) begin
              tx_message <= {21'd0, 1'b1, i_lost, 1'b0};
              tx_start   <= 1'b1;
              grant      <= 3'b010;
              state      <= TX;
            end else if (link_up && req_ball) begin
              tx_message <= {ball_y, vel_x, vel_y, sign_y, 1'b1, 5'd0};
              tx_start   <= 1'b1;
              grant      <= 3'b001;
              state      <= TX;
            end
          end
        end
        TX: begin
          if (busy_fall) state <= IDLE;
        end
        // DEAD keeps its own transmit-wait state so a reply never leads back to IDLE.
        DEAD: begin
          if (!tx_busy && pending_reply) begin
            tx_message    <= MSG_I_AM_HERE;
            tx_start      <= 1'b1;
            pending_reply <= 1'b0;
            state         <= DEAD_TX;
          end
        end
        DEAD_TX: begin
          if (busy_fall) state <= DEAD;
        end
        default: state <= PROBE_SEND;
      endcase

      // A request arriving while the reply is being launched still earns its own reply.
      if (rx_ayt_ev) pending_reply <= 1'b1;
    end
  end

endmodule

// File: tb/tb_comm_link_controller.sv
// Scoreboard bench for comm_link_controller: a transmitter model, a tx_start monitor
// popping expected words, and one task per scenario.
module tb_comm_link_controller;

  localparam int unsigned TO       = 64;
  localparam int unsigned RETRIES  = 3;
  localparam int unsigned BUSY_LEN = 6;

  logic        clock;
  logic        reset;
  logic        req_ball;
  logic [8:0]  ball_y;
  logic [3:0]  vel_x;
  logic [3:0]  vel_y;
  logic        sign_y;
  logic        req_miss;
  logic        i_lost;
  logic        req_new_game;
  logic [2:0]  grant;
  logic        tx_start;
  logic [23:0] tx_message;
  logic        tx_busy;
  logic        rx_new_message;
  logic        rx_are_you_there;
  logic        rx_I_am_here;
  logic        rx_message_acked;
  logic        rx_deliver;
  logic        link_up;
  logic        link_fail;

  typedef struct {
    logic [23:0] msg;
    logic [2:0]  grant;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  int unsigned cyc = 0;
  logic        start_seen;
  int          busy_left;
  logic [23:0] cur_msg;
  bit          cur_valid;

  comm_link_controller #(
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(RETRIES),
    .TO_W(7)
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_ball(req_ball),
    .ball_y(ball_y),
    .vel_x(vel_x),
    .vel_y(vel_y),
    .sign_y(sign_y),
    .req_miss(req_miss),
    .i_lost(i_lost),
    .req_new_game(req_new_game),
    .grant(grant),
    .tx_start(tx_start),
    .tx_message(tx_message),
    .tx_busy(tx_busy),
    .rx_new_message(rx_new_message),
    .rx_are_you_there(rx_are_you_there),
    .rx_I_am_here(rx_I_am_here),
    .rx_message_acked(rx_message_acked),
    .rx_deliver(rx_deliver),
    .link_up(link_up),
    .link_fail(link_fail)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [23:0] ball_word(logic [8:0] y, logic [3:0] vx, logic [3:0] vy, logic s);
    return {y, vx, vy, s, 1'b1, 5'b00000};
  endfunction

  // Transmitter model (busy for BUSY_LEN cycles starting the cycle after tx_start),
  // scoreboard pop on tx_start, and requester drop on grant.
  initial begin
    tx_busy    = 1'b0;
    start_seen = 1'b0;
    busy_left  = 0;
    cur_valid  = 1'b0;
    cur_msg    = '0;
    forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (start_seen) begin
        tx_busy   = 1'b1;
        busy_left = BUSY_LEN - 1;
      end else if (busy_left > 0) begin
        busy_left--;
      end else begin
        tx_busy = 1'b0;
      end
      start_seen = tx_start;
      if (reset) cur_valid = 1'b0;
      if (tx_start) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $display("FAIL tx_start_unexpected: got message %h grant %b, required no transmission", tx_message, grant);
        end else begin
          e = sb.pop_front();
          if (tx_message !== e.msg || grant !== e.grant) begin
            miscompares++;
            $display("FAIL tx_word: got message %h grant %b, required message %h grant %b",
                     tx_message, grant, e.msg, e.grant);
          end
          cur_msg   = e.msg;
          cur_valid = 1'b1;
        end
        if (grant[2]) req_new_game = 1'b0;
        if (grant[1]) req_miss = 1'b0;
        if (grant[0]) req_ball = 1'b0;
      end else begin
        if (grant !== 3'b000) begin
          vectors++;
          miscompares++;
          $display("FAIL grant_without_start: got grant %b, required 000", grant);
        end
        if (cur_valid && tx_busy && tx_message !== cur_msg) begin
          vectors++;
          miscompares++;
          $display("FAIL tx_hold: got message %h, required %h while busy", tx_message, cur_msg);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_start(output int unsigned at, input string tag);
    bit seen;
    seen = 1'b0;
    at = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (tx_start === 1'b1) begin
        seen = 1'b1;
        at = cyc;
      end
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s_start_timeout: got no tx_start, required one within 300 cycles", tag);
    end
  endtask

  task automatic wait_busy(input logic level, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      @(negedge clock);
      if (tx_busy === level) seen = 1'b1;
    end
    if (!seen) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_busy_timeout: got tx_busy stuck, required %b", tag, level);
    end
  endtask

  task automatic wait_sb_empty(input string tag);
    for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clock);
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL %s_sb_drain: got %0d words outstanding, required 0", tag, sb.size());
    end
  endtask

  task automatic apply_reset(input int n);
    @(negedge clock);
    reset = 1'b1;
    req_ball = 1'b0; req_miss = 1'b0; req_new_game = 1'b0;
    rx_new_message = 1'b0; rx_are_you_there = 1'b0; rx_I_am_here = 1'b0;
    tick(n);
    reset = 1'b0;
  endtask

  task automatic rx_msg(input logic ayt, input logic iah, input int hold, input int exp_del, input string tag);
    int acks, dels, both;
    acks = 0; dels = 0; both = 0;
    @(negedge clock);
    rx_are_you_there = ayt;
    rx_I_am_here     = iah;
    rx_new_message   = 1'b1;
    for (int i = 0; i < hold + 3; i++) begin
      @(negedge clock);
      if (rx_message_acked === 1'b1) acks++;
      if (rx_deliver === 1'b1) dels++;
      if (rx_message_acked === 1'b1 && rx_deliver === 1'b1) both++;
      if (i == hold - 1) begin
        rx_new_message = 1'b0; rx_are_you_there = 1'b0; rx_I_am_here = 1'b0;
      end
    end
    vectors += 2;
    if (acks != 1) begin
      miscompares++;
      $display("FAIL %s_acks: got %0d ack pulses, required 1", tag, acks);
    end
    if (dels != exp_del || both != exp_del) begin
      miscompares++;
      $display("FAIL %s_deliver: got %0d deliver (%0d with ack), required %0d", tag, dels, both, exp_del);
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    vectors++;
    if ({grant, tx_start, tx_message, rx_message_acked, rx_deliver, link_up, link_fail} !== '0) begin
      miscompares++;
      $display("FAIL %s: got grant %b start %b msg %h ack %b del %b up %b fail %b, required all 0",
               tag, grant, tx_start, tx_message, rx_message_acked, rx_deliver, link_up, link_fail);
    end
  endtask

  task automatic test_reset();
    tick(3);
    check_outputs_zero("reset_outputs_a");
    tick(2);
    check_outputs_zero("reset_outputs_b");
  endtask

  task automatic test_probe_timeout();
    int unsigned s, f;
    f = 0;
    for (int i = 0; i < 4; i++) sb.push_back('{24'h000010, 3'b000});
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_start(s, "probe_retry");
      // 64 counting cycles, then one PROBE_SEND cycle and the registered start
      if (i > 0) begin
        vectors++;
        if (s - f != TO + 2) begin
          miscompares++;
          $display("FAIL probe_gap%0d: got %0d cycles after busy fall, required %0d", i, s - f, TO + 2);
        end
      end
      wait_busy(1'b1, "probe_retry");
      wait_busy(1'b0, "probe_retry");
      f = cyc;
    end
    tick(TO + 10);
    vectors++;
    if (link_fail !== 1'b1 || link_up !== 1'b0) begin
      miscompares++;
      $display("FAIL link_fail_after_retries: got fail %b up %b, required fail 1 up 0", link_fail, link_up);
    end
    wait_sb_empty("probe_retry");
    // DEAD: game requests ignored, are_you_there still answered, I_am_here ignored
    ball_y = 9'h055; vel_x = 4'd1; vel_y = 4'd2; sign_y = 1'b0;
    req_ball = 1'b1;
    sb.push_back('{24'h000008, 3'b000});
    rx_msg(1'b1, 1'b0, 1, 0, "dead_ayt");
    wait_sb_empty("dead_reply");
    rx_msg(1'b0, 1'b1, 1, 0, "dead_iah");
    tick(30);
    req_ball = 1'b0;
    vectors++;
    if (link_up !== 1'b0 || link_fail !== 1'b1) begin
      miscompares++;
      $display("FAIL dead_sticky: got up %b fail %b, required up 0 fail 1", link_up, link_fail);
    end
  endtask

  task automatic test_probe_ok();
    int unsigned s;
    sb.push_back('{24'h000010, 3'b000});
    apply_reset(2);
    wait_start(s, "probe_ok");
    wait_busy(1'b1, "probe_ok");
    wait_busy(1'b0, "probe_ok");
    tick(49);
    rx_msg(1'b0, 1'b1, 1, 0, "probe_iah");
    vectors++;
    if (link_up !== 1'b1 || link_fail !== 1'b0) begin
      miscompares++;
      $display("FAIL link_up_after_reply: got up %b fail %b, required up 1 fail 0", link_up, link_fail);
    end
    tick(2 * TO);
    wait_sb_empty("probe_ok");
  endtask

  task automatic test_arbitration();
    ball_y = 9'h1A5; vel_x = 4'd3; vel_y = 4'd5; sign_y = 1'b1; i_lost = 1'b1;
    sb.push_back('{24'h000001, 3'b100});
    sb.push_back('{24'h000006, 3'b010});
    sb.push_back('{ball_word(9'h1A5, 4'd3, 4'd5, 1'b1), 3'b001});
    @(negedge clock);
    req_ball = 1'b1; req_miss = 1'b1; req_new_game = 1'b1;
    wait_sb_empty("arbitration");
    tick(BUSY_LEN + 6);
  endtask

  task automatic test_reply_priority();
    sb.push_back('{ball_word(9'h0FF, 4'd15, 4'd0, 1'b0), 3'b001});
    @(negedge clock);
    ball_y = 9'h0FF; vel_x = 4'd15; vel_y = 4'd0; sign_y = 1'b0;
    req_ball = 1'b1;
    wait_sb_empty("reply_first_ball");
    wait_busy(1'b1, "reply_prio");
    sb.push_back('{24'h000008, 3'b000});
    sb.push_back('{ball_word(9'h102, 4'd7, 4'd9, 1'b1), 3'b001});
    ball_y = 9'h102; vel_x = 4'd7; vel_y = 4'd9; sign_y = 1'b1;
    req_ball = 1'b1;
    rx_msg(1'b1, 1'b0, 1, 0, "ayt_during_tx");
    wait_sb_empty("reply_prio");
    tick(BUSY_LEN + 6);
  endtask

  task automatic test_rx_deliver();
    rx_msg(1'b0, 1'b0, 5, 1, "game_msg_held");
    rx_msg(1'b0, 1'b0, 1, 1, "game_msg_short");
    rx_msg(1'b0, 1'b1, 1, 0, "iah_in_idle");
    vectors++;
    if (link_up !== 1'b1) begin
      miscompares++;
      $display("FAIL link_up_kept: got %b, required 1", link_up);
    end
  endtask

  task automatic test_reset_mid_tx();
    int unsigned s;
    sb.push_back('{ball_word(9'h003, 4'd2, 4'd4, 1'b0), 3'b001});
    @(negedge clock);
    ball_y = 9'h003; vel_x = 4'd2; vel_y = 4'd4; sign_y = 1'b0;
    req_ball = 1'b1;
    wait_sb_empty("mid_tx_ball");
    wait_busy(1'b1, "mid_tx");
    sb.push_back('{24'h000010, 3'b000});
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_outputs_zero("reset_mid_tx_outputs");
    wait_start(s, "probe_after_reset");
    vectors++;
    if (busy_left != 0 || link_up !== 1'b0) begin
      miscompares++;
      $display("FAIL probe_after_reset: got busy_left %0d up %b, required 0 and 0", busy_left, link_up);
    end
    wait_sb_empty("probe_after_reset");
    tick(BUSY_LEN + 4);
  endtask

  initial begin
    reset = 1'b1;
    req_ball = 1'b0; req_miss = 1'b0; req_new_game = 1'b0;
    ball_y = '0; vel_x = '0; vel_y = '0; sign_y = 1'b0; i_lost = 1'b0;
    rx_new_message = 1'b0; rx_are_you_there = 1'b0; rx_I_am_here = 1'b0;
    test_reset();
    test_probe_timeout();
    test_probe_ok();
    test_arbitration();
    test_reply_priority();
    test_rx_deliver();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, required finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
